alu_result_stage: RTL and testbench

Registered result/flag stage directly downstream of the 8-bit add/subtract unit in the simple ALU. Accepts one adder result per beat with its operands and mode bit, and derives Z/N/C/V flags. Optionally writes the result into an accumulator that feeds back as the next x operand. Presents results through a 2-entry output buffer with valid/ready flow control, and keeps a sticky overflow flag.

---
 rtl/alu_result_stage.sv | 134 +++++++++++++
 tb/tb_alu_result_stage.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//
// Registered result/flag stage that sits after the 8-bit add/subtract unit.
// Each accepted beat carries the adder result plus its operands and mode bit.
// The stage derives the {V,C,N,Z} flags and stores them with the result in a
// 2-entry in-order output buffer. It can also load the result into an
// accumulator that feeds back as the next x operand, and it keeps a sticky
// overflow flag.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   in_valid    upstream beat valid
//   in_ready    stage can accept a beat (registered, independent of out_ready)
//   in_x        x operand given to the adder
//   in_y        y operand given to the adder (before conditional inversion)
//   in_sub      adder mode: 0 add, 1 subtract
//   in_res      adder result
//   in_co       adder carry-out (borrow on subtract), passed through as C
//   in_acc_we   load in_res into the accumulator when the beat is accepted
//   clr_sticky  synchronous clear of sticky_v (an overflow in the same cycle wins)
//   out_valid   buffered result available
//   out_ready   downstream accepts the head entry
//   out_res     head result
//   out_flags   head flags {V,C,N,Z}
//   acc         accumulator value
//   sticky_v    set by any accepted beat whose V flag is 1
// -----------------------------------------------------------------------------
module alu_result_stage #(
    parameter int W     = 8,
    parameter int DEPTH = 2     // only 2 is supported
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_x,
    input  logic [W-1:0] in_y,
    input  logic         in_sub,
    input  logic [W-1:0] in_res,
    input  logic         in_co,
    input  logic         in_acc_we,
    input  logic         clr_sticky,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_res,
    output logic [3:0]   out_flags,
    output logic [W-1:0] acc,
    output logic         sticky_v
);

    localparam int EW = W + 4;  // {V,C,N,Z,result}

    logic [1:0]    count_q, count_d;
    logic          wr_ptr_q, rd_ptr_q;
    logic          in_ready_q;
    logic [W-1:0]  acc_q;
    logic          sticky_q, sticky_d;

    logic          push, pop;
    logic          flag_z, flag_n, flag_c, flag_v;
    logic [EW-1:0] new_entry;
    logic [EW-1:0] head_entry;

    assign push = in_valid && in_ready_q;
    assign pop  = (count_q != 2'd0) && out_ready;

    // Flags are derived from the operand and result sign bits. On subtract,
    // the adder sees ~y, so overflow needs the operand signs to differ.
    assign flag_z = (in_res == '0);
    assign flag_n = in_res[W-1];
    assign flag_c = in_co;
    assign flag_v = in_sub ? ((in_x[W-1] != in_y[W-1]) && (in_res[W-1] != in_x[W-1]))
                           : ((in_x[W-1] == in_y[W-1]) && (in_res[W-1] != in_x[W-1]));

    assign new_entry = {flag_v, flag_c, flag_n, flag_z, in_res};

    // The buffer never holds more than 2 entries, because push is blocked when full.
    assign count_d  = count_q + {1'b0, push} - {1'b0, pop};
    // Overflow in the same cycle takes priority over the clear.
    assign sticky_d = (sticky_q && !clr_sticky) || (push && flag_v);

    // Buffer storage: one register per slot, written when the write pointer
    // selects it.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_entry
            logic [EW-1:0] entry_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_q <= '0;
                end else if (push && (wr_ptr_q == 1'(gi))) begin
                    entry_q <= new_entry;
                end
            end
        end
    endgenerate

    assign head_entry = rd_ptr_q ? gen_entry[1].entry_q : gen_entry[0].entry_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            in_ready_q <= 1'b0;     // goes high on the first edge after release
            acc_q      <= '0;
            sticky_q   <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_q ^ push;
            rd_ptr_q   <= rd_ptr_q ^ pop;
            // Ready is taken from the next count, so there is no
            // combinational path from out_ready to in_ready.
            in_ready_q <= (count_d < 2'(DEPTH));
            sticky_q   <= sticky_d;
            // The accumulator follows accepted beats even when the output
            // side is stalled.
            if (push && in_acc_we) begin
                acc_q <= in_res;
            end
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (count_q != 2'd0);
    assign out_res   = head_entry[W-1:0];
    assign out_flags = head_entry[EW-1:W];
    assign acc       = acc_q;
    assign sticky_v  = sticky_q;

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x, in_y, in_res;
    logic       in_sub, in_co, in_acc_we, clr_sticky;
    logic       out_valid, out_ready;
    logic [7:0] out_res;
    logic [3:0] out_flags;
    logic [7:0] acc;
    logic       sticky_v;

    int checks = 0;
    int errors = 0;

    // Reference model state: expected buffer contents as {flags, result}.
    logic [11:0] m_q[$];
    logic [7:0]  m_acc;
    bit          m_sticky;
    bit          m_ready;

    alu_result_stage #(.W(8), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_sub(in_sub),
        .in_res(in_res), .in_co(in_co), .in_acc_we(in_acc_we),
        .clr_sticky(clr_sticky),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_flags(out_flags),
        .acc(acc), .sticky_v(sticky_v)
    );

    always #5 clk = ~clk;

    task automatic check_all(input string tag);
        bit ev;
        ev = (m_q.size() != 0);
        checks++;
        assert (in_ready === m_ready) else begin
            errors++; $error("FAIL %s in_ready got %0b exp %0b", tag, in_ready, m_ready);
        end
        checks++;
        assert (out_valid === ev) else begin
            errors++; $error("FAIL %s out_valid got %0b exp %0b", tag, out_valid, ev);
        end
        if (ev) begin
            checks++;
            assert (out_res === m_q[0][7:0]) else begin
                errors++; $error("FAIL %s out_res got %02h exp %02h", tag, out_res, m_q[0][7:0]);
            end
            checks++;
            assert (out_flags === m_q[0][11:8]) else begin
                errors++; $error("FAIL %s out_flags got %04b exp %04b", tag, out_flags, m_q[0][11:8]);
            end
        end
        checks++;
        assert (acc === m_acc) else begin
            errors++; $error("FAIL %s acc got %02h exp %02h", tag, acc, m_acc);
        end
        checks++;
        assert (sticky_v === m_sticky) else begin
            errors++; $error("FAIL %s sticky_v got %0b exp %0b", tag, sticky_v, m_sticky);
        end
    endtask

    // One clock cycle: drive the adder beat (result and carry computed here
    // with plain arithmetic), advance the model, then check on the falling edge.
    task automatic step(input string tag, input bit v, input logic [7:0] x, input logic [7:0] y,
                        input bit sub, input bit we, input bit clr, input bit ordy);
        int  sx, sy, sr, ux, uy;
        bit  vf, co, push, pop;
        logic [7:0] r;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        sr = sub ? (sx - sy) : (sx + sy);
        vf = (sr > 127) || (sr < -128);
        co = sub ? (ux < uy) : ((ux + uy) > 255);
        r  = sub ? 8'(ux - uy) : 8'(ux + uy);

        in_valid = v; in_x = x; in_y = y; in_sub = sub; in_res = r; in_co = co;
        in_acc_we = we; clr_sticky = clr; out_ready = ordy;

        push = v && m_ready;
        pop  = (m_q.size() != 0) && ordy;
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (push) m_q.push_back({vf, co, r[7], (r == 8'h00), r});
        if (push && we) m_acc = r;
        if (push && vf) m_sticky = 1'b1;
        else if (clr) m_sticky = 1'b0;
        m_ready = (m_q.size() < 2);
        @(negedge clk);
        $display("%s: v=%0b x=%02h y=%02h sub=%0b res=%02h push=%0b pop=%0b | out_v=%0b out=%02h fl=%04b acc=%02h st=%0b rdy=%0b",
                 tag, v, x, y, sub, r, push, pop, out_valid, out_res, out_flags, acc, sticky_v, in_ready);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input bit clr, input bit ordy);
        step(tag, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, clr, ordy);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_x = 0; in_y = 0; in_sub = 0; in_res = 0; in_co = 0;
        in_acc_we = 0; clr_sticky = 0; out_ready = 0;
        m_acc = 8'h00; m_sticky = 0; m_ready = 0;

        repeat (3) @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        idle("release", 1'b0, 1'b0);

        // Add with overflow: 7F + 01 = 80, flags 1010, sticky set.
        step("add_ovf", 1, 8'h7F, 8'h01, 0, 0, 0, 1);
        checks++;
        assert (out_flags === 4'b1010) else begin
            errors++; $error("FAIL add_ovf_flags got %04b exp 1010", out_flags);
        end
        // Subtract to zero: flags 0001.
        step("sub_zero", 1, 8'h05, 8'h05, 1, 0, 0, 1);
        checks++;
        assert (out_flags === 4'b0001) else begin
            errors++; $error("FAIL sub_zero_flags got %04b exp 0001", out_flags);
        end
        // Subtract with borrow and accumulator write: flags 0110, acc FE.
        step("sub_borrow", 1, 8'h03, 8'h05, 1, 1, 0, 1);
        checks++;
        assert (acc === 8'hFE) else begin
            errors++; $error("FAIL sub_borrow_acc got %02h exp FE", acc);
        end
        idle("drain", 0, 1);

        // Backpressure: three beats offered with out_ready low.
        step("bp_b1", 1, 8'h11, 8'h01, 0, 0, 0, 0);
        step("bp_b2", 1, 8'h22, 8'h02, 0, 0, 0, 0);
        checks++;
        assert (in_ready === 1'b0) else begin
            errors++; $error("FAIL bp_full in_ready got %0b exp 0", in_ready);
        end
        step("bp_b3_blocked", 1, 8'h33, 8'h03, 0, 0, 0, 0);
        step("bp_pop1", 1, 8'h33, 8'h03, 0, 0, 0, 1);
        step("bp_b3_accept", 1, 8'h33, 8'h03, 0, 0, 0, 1);
        idle("bp_drain1", 0, 1);
        idle("bp_drain2", 0, 1);

        // Sticky collision: set, then clear plus V=1 beat (set wins), then clear.
        step("st_set", 1, 8'h80, 8'h01, 1, 0, 0, 1);
        step("st_collide", 1, 8'h40, 8'h40, 0, 0, 1, 1);
        checks++;
        assert (sticky_v === 1'b1) else begin
            errors++; $error("FAIL st_collide got %0b exp 1", sticky_v);
        end
        idle("st_clear", 1, 1);
        checks++;
        assert (sticky_v === 1'b0) else begin
            errors++; $error("FAIL st_clear got %0b exp 0", sticky_v);
        end
        idle("st_drain", 0, 1);

        // Randomized traffic with accumulator feedback.
        for (int i = 0; i < 300; i++) begin
            logic [7:0] rx;
            rx = ($urandom_range(0, 1) == 1) ? m_acc : 8'($urandom);
            step("rand", ($urandom_range(0, 9) < 7), rx, 8'($urandom), 1'($urandom),
                 1'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 6));
        end
        idle("rand_drain1", 0, 1);
        idle("rand_drain2", 0, 1);

        // Asynchronous reset with two entries buffered and acc=3C.
        step("ar_b1", 1, 8'h3C, 8'h00, 0, 1, 0, 0);
        step("ar_b2", 1, 8'h7F, 8'h01, 0, 0, 0, 0);
        checks++;
        assert (out_valid === 1'b1 && acc === 8'h3C && sticky_v === 1'b1) else begin
            errors++; $error("FAIL ar_setup got v=%0b acc=%02h st=%0b exp v=1 acc=3C st=1", out_valid, acc, sticky_v);
        end
        in_valid = 0;
        #2 rst_n = 1'b0;
        #1;
        $display("async_reset: out_v=%0b acc=%02h st=%0b rdy=%0b", out_valid, acc, sticky_v, in_ready);
        m_q.delete();
        m_acc = 8'h00; m_sticky = 0; m_ready = 0;
        check_all("async_reset");
        @(negedge clk);
        check_all("in_reset");
        rst_n = 1'b1;
        idle("post_reset", 0, 1);
        step("post_beat", 1, 8'h01, 8'h02, 0, 0, 0, 1);
        idle("post_drain", 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
